cmp_window_monitor: RTL and testbench
=====================================

# cmp_window_monitor

Multi-channel, parametrised window comparator with debounced alarm generation. Each cycle with a valid sample vector, every channel compares its WIDTH-bit value against shared programmable low/high thresholds (unsigned or signed), registers below/above flags, and raises a per-channel alarm after DEBOUNCE consecutive out-of-window samples. It sits in the comparison/optimisation regression designs as a sequential consumer of constant and programmable relational compares, including the all-zeros, all-ones and sign-boundary edge cases.

## Interface
- WIDTH, 4, sample and threshold width (>=2)
- CHANNELS, 4, number of independent channels (>=1)
- DEBOUNCE, 3, consecutive out-of-window valid samples needed to alarm (>=1)
- SIGNED, 0, 1 = two's-complement compares, 0 = unsigned
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- in_valid  in  1  sample vector valid this cycle
- in_data  in  CHANNELS*WIDTH  channel c at bits [c*WIDTH +: WIDTH]
- cfg_load  in  1  capture lo_thr/hi_thr
- lo_thr  in  WIDTH  low threshold
- hi_thr  in  WIDTH  high threshold
- clear  in  1  clear all counters and alarms
- out_valid  out  1  registered in_valid
- below  out  CHANNELS  sample < lo (registered)
- above  out  CHANNELS  sample > hi (registered)
- alarm  out  CHANNELS  debounced out-of-window alarm

## Operation
- Per channel: out = below | above; equality with either threshold is in-window.
- Compares use SIGNED mode for sample and thresholds alike; no width extension beyond WIDTH.
- lo > hi (inverted window): every sample is out-of-window; no special casing.
- Per-channel FSM: IDLE (count 0) -> PEND (0 < count < DEBOUNCE) -> ALARM (count = DEBOUNCE). Counter width clog2(DEBOUNCE+1), saturates at DEBOUNCE.
- Valid out-of-window sample: count+1 (saturating); reaching DEBOUNCE enters ALARM.
- Valid in-window sample: count -> 0, state -> IDLE.
- in_valid = 0: state, count, below, above hold; out_valid = 0.
- clear: counters and states return to IDLE, then a same-cycle valid sample is evaluated from IDLE (out-of-window gives count 1, or ALARM if DEBOUNCE = 1).
- cfg_load: thresholds registered; a sample in the same cycle uses the old thresholds.

## Timing
- Reset values: out_valid 0, below 0, above 0, alarm 0, all counts 0, state IDLE; lo register = minimum representable value (0 unsigned, 100..0 signed); hi register = maximum (all ones unsigned, 011..1 signed), so no sample is out-of-window after reset.
- Latency: sample at edge t -> out_valid/below/above visible after edge t+1.
- alarm is registered and asserts in the same cycle as the flags of the DEBOUNCE-th consecutive out-of-window sample. It deasserts (non-sticky) in the cycle the first in-window flags appear.
- Reset mid-PEND or ALARM: immediate asynchronous return to reset values.

## Configuration
- CMP_WINDOW_STICKY_EN defined: ALARM is sticky. In-window samples reset count but alarm stays 1 until clear or reset.
- Undefined: alarm follows ALARM state exactly as in Operation.

## Structure
- Package cmp_window_pkg: state enum (IDLE, PEND, ALARM), functions thr_min(WIDTH,SIGNED) and thr_max(WIDTH,SIGNED), counter-width helper.
- Sub-module cmp_window_chan: one channel (compare, counter, FSM, flag and alarm registers), instantiated CHANNELS times by generate. Threshold and out_valid registers live in the top level.

## Test plan
- Reset defaults: no cfg_load, valid samples 4'b0000 and 4'b1111 on all channels -> below = above = alarm = 0, out_valid pulses one cycle after each.
- Unsigned bounds: lo=4, hi=9; samples 3,4,9,10 -> below only for 3, above only for 10, 4 and 9 in-window.
- Signed (SIGNED=1): lo=4'b1110 (-2), hi=3; samples 4'b1000, 4'b0111, 4'b1111 -> below, above, in-window respectively.
- Debounce: three out-of-window valid samples with in_valid=0 gaps between them -> alarm rises with the third sample's flags. A following in-window sample drops alarm (non-sticky) or holds it (CMP_WINDOW_STICKY_EN).
- clear with a concurrent out-of-window sample while in ALARM -> alarm 0 next cycle, count 1; two more out-of-window samples -> alarm 1.
- cfg_load same cycle as sample 8 (old hi=9, new hi=7) -> in-window. Next sample 8 -> above. rst_n pulse while in PEND -> all outputs 0 immediately.

Source files
------------

// File: rtl/cmp_window_pkg.sv
// Shared types and constant helpers for the multi-channel window comparator.
package cmp_window_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PEND  = 2'd1,
      ALARM = 2'd2
   } cmp_state_e;

   function automatic logic [63:0] thr_min(input int width, input bit sgn);
      return sgn ? (64'd1 << (width - 1)) : 64'd0;
   endfunction

   function automatic logic [63:0] thr_max(input int width, input bit sgn);
      return sgn ? ({64{1'b1}} >> (65 - width)) : ({64{1'b1}} >> (64 - width));
   endfunction

   function automatic int cnt_w(input int debounce);
      return $clog2(debounce + 1);
   endfunction

endpackage

// File: rtl/cmp_window_monitor_if.sv
// Sample, threshold-programming and result signals of the window comparator.
interface cmp_window_monitor_if #(
   parameter int WIDTH    = 4,
   parameter int CHANNELS = 4
);
   logic                      in_valid;
   logic [CHANNELS*WIDTH-1:0] in_data;
   logic                      cfg_load;
   logic [WIDTH-1:0]          lo_thr;
   logic [WIDTH-1:0]          hi_thr;
   logic                      clear;
   logic                      out_valid;
   logic [CHANNELS-1:0]       below;
   logic [CHANNELS-1:0]       above;
   logic [CHANNELS-1:0]       alarm;

   modport master (
      output in_valid, in_data, cfg_load, lo_thr, hi_thr, clear,
      input  out_valid, below, above, alarm
   );

   modport slave (
      input  in_valid, in_data, cfg_load, lo_thr, hi_thr, clear,
      output out_valid, below, above, alarm
   );
endinterface

// File: rtl/cmp_window_chan.sv
// One comparator channel: window compare, debounce counter/FSM, flag and alarm registers.
// CMP_WINDOW_STICKY_EN makes the alarm hold until clear or reset.
module cmp_window_chan
   import cmp_window_pkg::*;
#(
   parameter int WIDTH    = 4,
   parameter int DEBOUNCE = 3,
   parameter int SIGNED   = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             valid_i,
   input  logic             clear_i,
   input  logic [WIDTH-1:0] sample_i,
   input  logic [WIDTH-1:0] lo_i,
   input  logic [WIDTH-1:0] hi_i,
   output logic             below_o,
   output logic             above_o,
   output logic             alarm_o
);
   localparam int            CW      = cnt_w(DEBOUNCE);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE);

   cmp_state_e    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d, cnt_base;
   logic          below_q, below_d, above_q, above_d, alarm_q, alarm_d;
   logic          lt_lo, gt_hi;

   always_comb begin
      if (SIGNED != 0) begin
         lt_lo = $signed(sample_i) < $signed(lo_i);
         gt_hi = $signed(sample_i) > $signed(hi_i);
      end else begin
         lt_lo = sample_i < lo_i;
         gt_hi = sample_i > hi_i;
      end
   end

   // clear is applied first so a same-cycle sample is evaluated from IDLE
   always_comb begin
      state_d  = clear_i ? IDLE : state_q;
      cnt_base = clear_i ? '0 : cnt_q;
      cnt_d    = cnt_base;
      below_d  = below_q;
      above_d  = above_q;
      if (valid_i) begin
         below_d = lt_lo;
         above_d = gt_hi;
         if (lt_lo || gt_hi) begin
            if (cnt_base != CNT_MAX) cnt_d = cnt_base + CW'(1);
            state_d = (cnt_d == CNT_MAX) ? ALARM : PEND;
         end else begin
            cnt_d   = '0;
            state_d = IDLE;
         end
      end
`ifdef CMP_WINDOW_STICKY_EN
      alarm_d = (state_d == ALARM) || (alarm_q && !clear_i);
`else
      alarm_d = (state_d == ALARM);
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         below_q <= 1'b0;
         above_q <= 1'b0;
         alarm_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         below_q <= below_d;
         above_q <= above_d;
         alarm_q <= alarm_d;
      end
   end

   assign below_o = below_q;
   assign above_o = above_q;
   assign alarm_o = alarm_q;
endmodule

// File: rtl/cmp_window_monitor.sv
// Multi-channel window comparator with debounced per-channel alarms; shared threshold registers.
// Define CMP_WINDOW_STICKY_EN for alarms that hold until clear or reset.
module cmp_window_monitor
   import cmp_window_pkg::*;
#(
   parameter int WIDTH    = 4,
   parameter int CHANNELS = 4,
   parameter int DEBOUNCE = 3,
   parameter int SIGNED   = 0
) (
   input logic                clk,
   input logic                rst_n,
   cmp_window_monitor_if.slave bus
);
   // Reset window spans the whole range so nothing is out-of-window before programming
   localparam logic [WIDTH-1:0] LO_INIT = WIDTH'(thr_min(WIDTH, SIGNED != 0));
   localparam logic [WIDTH-1:0] HI_INIT = WIDTH'(thr_max(WIDTH, SIGNED != 0));

   logic [WIDTH-1:0]    lo_q, lo_d, hi_q, hi_d;
   logic                out_valid_q;
   logic [CHANNELS-1:0] below_w, above_w, alarm_w;

   always_comb begin
      lo_d = lo_q;
      hi_d = hi_q;
      if (bus.cfg_load) begin
         lo_d = bus.lo_thr;
         hi_d = bus.hi_thr;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lo_q        <= LO_INIT;
         hi_q        <= HI_INIT;
         out_valid_q <= 1'b0;
      end else begin
         lo_q        <= lo_d;
         hi_q        <= hi_d;
         out_valid_q <= bus.in_valid;
      end
   end

   for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
      cmp_window_chan #(
         .WIDTH   (WIDTH),
         .DEBOUNCE(DEBOUNCE),
         .SIGNED  (SIGNED)
      ) u_chan (
         .clk     (clk),
         .rst_n   (rst_n),
         .valid_i (bus.in_valid),
         .clear_i (bus.clear),
         .sample_i(bus.in_data[c*WIDTH +: WIDTH]),
         .lo_i    (lo_q),
         .hi_i    (hi_q),
         .below_o (below_w[c]),
         .above_o (above_w[c]),
         .alarm_o (alarm_w[c])
      );
   end

   assign bus.out_valid = out_valid_q;
   assign bus.below     = below_w;
   assign bus.above     = above_w;
   assign bus.alarm     = alarm_w;
endmodule

// File: tb/tb_cmp_window_monitor.sv
// Drives an unsigned and a signed cmp_window_monitor with identical stimulus and checks both against a behavioural model.
module tb_cmp_window_monitor;
   localparam int W  = 4;
   localparam int CH = 4;
   localparam int DB = 3;

`ifdef CMP_WINDOW_STICKY_EN
   localparam logic [CH-1:0] ALARM_AFTER_INWIN = 4'b1111;
`else
   localparam logic [CH-1:0] ALARM_AFTER_INWIN = 4'b0000;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   cmp_window_monitor_if #(.WIDTH(W), .CHANNELS(CH)) if_u ();
   cmp_window_monitor_if #(.WIDTH(W), .CHANNELS(CH)) if_s ();

   cmp_window_monitor #(.WIDTH(W), .CHANNELS(CH), .DEBOUNCE(DB), .SIGNED(0)) dut_u (
      .clk(clk), .rst_n(rst_n), .bus(if_u));
   cmp_window_monitor #(.WIDTH(W), .CHANNELS(CH), .DEBOUNCE(DB), .SIGNED(1)) dut_s (
      .clk(clk), .rst_n(rst_n), .bus(if_s));

   int n_checks = 0;
   int n_pass   = 0;

   // Model state: index 0 = unsigned instance, 1 = signed instance
   logic [W-1:0]  m_lo [2];
   logic [W-1:0]  m_hi [2];
   int            m_cnt [2][CH];
   logic [CH-1:0] m_below [2];
   logic [CH-1:0] m_above [2];
   logic [CH-1:0] m_alarm [2];
   logic          m_ov [2];

   function automatic int sval(input logic [W-1:0] x, input int k);
      if (k == 1) return int'($signed(x));
      return int'(x);
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_lo[k]    = (k == 1) ? 4'b1000 : 4'b0000;
         m_hi[k]    = (k == 1) ? 4'b0111 : 4'b1111;
         m_below[k] = '0;
         m_above[k] = '0;
         m_alarm[k] = '0;
         m_ov[k]    = 1'b0;
         for (int c = 0; c < CH; c++) m_cnt[k][c] = 0;
      end
   endtask

   task automatic model_step(input logic v, input logic [CH*W-1:0] d, input logic cl,
                             input logic cfg, input logic [W-1:0] lo, input logic [W-1:0] hi);
      for (int k = 0; k < 2; k++) begin
         m_ov[k] = v;
         for (int c = 0; c < CH; c++) begin
            int  x;
            bit  b, a;
            if (cl) begin
               m_cnt[k][c]   = 0;
               m_alarm[k][c] = 1'b0;
            end
            if (v) begin
               x = sval(d[c*W +: W], k);
               b = x < sval(m_lo[k], k);
               a = x > sval(m_hi[k], k);
               m_below[k][c] = b;
               m_above[k][c] = a;
               if (b || a) m_cnt[k][c] = (m_cnt[k][c] < DB) ? m_cnt[k][c] + 1 : DB;
               else        m_cnt[k][c] = 0;
            end
`ifdef CMP_WINDOW_STICKY_EN
            m_alarm[k][c] = m_alarm[k][c] | (m_cnt[k][c] == DB);
`else
            m_alarm[k][c] = (m_cnt[k][c] == DB);
`endif
         end
         if (cfg) begin
            m_lo[k] = lo;
            m_hi[k] = hi;
         end
      end
   endtask

   task automatic chk(input string tag, input logic [CH-1:0] obs, input logic [CH-1:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
   endtask

   task automatic check_all(input string tag);
      chk({tag, "/u_out_valid"}, {3'b000, if_u.out_valid}, {3'b000, m_ov[0]});
      chk({tag, "/u_below"},     if_u.below,  m_below[0]);
      chk({tag, "/u_above"},     if_u.above,  m_above[0]);
      chk({tag, "/u_alarm"},     if_u.alarm,  m_alarm[0]);
      chk({tag, "/s_out_valid"}, {3'b000, if_s.out_valid}, {3'b000, m_ov[1]});
      chk({tag, "/s_below"},     if_s.below,  m_below[1]);
      chk({tag, "/s_above"},     if_s.above,  m_above[1]);
      chk({tag, "/s_alarm"},     if_s.alarm,  m_alarm[1]);
   endtask

   task automatic drive(input logic v, input logic [CH*W-1:0] d, input logic cl,
                        input logic cfg, input logic [W-1:0] lo, input logic [W-1:0] hi);
      if_u.in_valid = v;  if_u.in_data = d;  if_u.clear = cl;
      if_u.cfg_load = cfg; if_u.lo_thr = lo; if_u.hi_thr = hi;
      if_s.in_valid = v;  if_s.in_data = d;  if_s.clear = cl;
      if_s.cfg_load = cfg; if_s.lo_thr = lo; if_s.hi_thr = hi;
   endtask

   task automatic step(input string tag, input logic v, input logic [CH*W-1:0] d, input logic cl,
                       input logic cfg, input logic [W-1:0] lo, input logic [W-1:0] hi);
      @(negedge clk);
      drive(v, d, cl, cfg, lo, hi);
      @(posedge clk);
      #1;
      model_step(v, d, cl, cfg, lo, hi);
      check_all(tag);
   endtask

   task automatic idle(input string tag);
      step(tag, 1'b0, '0, 1'b0, 1'b0, '0, '0);
   endtask

   initial begin
      drive(1'b0, '0, 1'b0, 1'b0, '0, '0);
      model_reset();
      #2;
      check_all("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // Reset thresholds: all-zeros and all-ones are in-window
      step("rst_zeros", 1'b1, 16'h0000, 1'b0, 1'b0, '0, '0);
      chk("rst_zeros_ov", {3'b000, if_u.out_valid}, 4'b0001);
      step("rst_ones", 1'b1, 16'hFFFF, 1'b0, 1'b0, '0, '0);
      chk("rst_ones_flags", if_u.below | if_u.above | if_s.below | if_s.above, 4'b0000);
      idle("rst_gap");
      chk("rst_gap_ov", {3'b000, if_u.out_valid}, 4'b0000);

      // Signed window -2..3
      step("s_cfg", 1'b0, '0, 1'b0, 1'b1, 4'b1110, 4'b0011);
      step("s_cmp", 1'b1, {4'b0000, 4'b1111, 4'b0111, 4'b1000}, 1'b0, 1'b0, '0, '0);
      chk("signed_below", if_s.below, 4'b0001);
      chk("signed_above", if_s.above, 4'b0010);

      // Unsigned window 4..9
      step("u_cfg", 1'b0, '0, 1'b0, 1'b1, 4'd4, 4'd9);
      step("u_cmp", 1'b1, {4'd10, 4'd9, 4'd4, 4'd3}, 1'b0, 1'b0, '0, '0);
      chk("unsigned_below", if_u.below, 4'b0001);
      chk("unsigned_above", if_u.above, 4'b1000);

      // Debounce across in_valid gaps
      step("db_inwin", 1'b1, 16'h5555, 1'b0, 1'b0, '0, '0);
      step("db_s1", 1'b1, 16'hFFFF, 1'b0, 1'b0, '0, '0);
      idle("db_g1");
      step("db_s2", 1'b1, 16'hFFFF, 1'b0, 1'b0, '0, '0);
      chk("db_second_no_alarm", if_u.alarm, 4'b0000);
      idle("db_g2");
      step("db_s3", 1'b1, 16'hFFFF, 1'b0, 1'b0, '0, '0);
      chk("db_third_alarm", if_u.alarm, 4'b1111);
      step("db_back", 1'b1, 16'h5555, 1'b0, 1'b0, '0, '0);
      chk("db_inwin_alarm", if_u.alarm, ALARM_AFTER_INWIN);

      // clear with concurrent out-of-window sample while alarmed
      step("cl_a1", 1'b1, 16'hFFFF, 1'b0, 1'b0, '0, '0);
      step("cl_a2", 1'b1, 16'hFFFF, 1'b0, 1'b0, '0, '0);
      step("cl_a3", 1'b1, 16'hFFFF, 1'b0, 1'b0, '0, '0);
      chk("cl_pre_alarm", if_u.alarm, 4'b1111);
      step("cl_clear", 1'b1, 16'hFFFF, 1'b1, 1'b0, '0, '0);
      chk("cl_alarm_cleared", if_u.alarm, 4'b0000);
      step("cl_b2", 1'b1, 16'hFFFF, 1'b0, 1'b0, '0, '0);
      chk("cl_count2_no_alarm", if_u.alarm, 4'b0000);
      step("cl_b3", 1'b1, 16'hFFFF, 1'b0, 1'b0, '0, '0);
      chk("cl_realarm", if_u.alarm, 4'b1111);

      // cfg_load uses old thresholds for the same-cycle sample
      step("cfg_same", 1'b1, 16'h8888, 1'b0, 1'b1, 4'd4, 4'd7);
      chk("cfg_old_hi", if_u.above, 4'b0000);
      step("cfg_next", 1'b1, 16'h8888, 1'b0, 1'b0, '0, '0);
      chk("cfg_new_hi", if_u.above, 4'b1111);

      // Asynchronous reset while pending
      step("pend", 1'b1, 16'hFFFF, 1'b0, 1'b0, '0, '0);
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      chk("async_rst_flags", if_u.below | if_u.above | if_u.alarm, 4'b0000);
      check_all("async_rst");
      @(negedge clk);
      rst_n = 1'b1;

      // Randomised traffic
      for (int i = 0; i < 300; i++) begin
         logic             v, cl, cfg;
         logic [CH*W-1:0]  d;
         logic [W-1:0]     lo, hi;
         v   = ($urandom_range(0, 3) != 0);
         cl  = ($urandom_range(0, 15) == 0);
         cfg = ($urandom_range(0, 11) == 0);
         d   = CH*W'($urandom);
         lo  = W'($urandom);
         hi  = W'($urandom);
         step("rand", v, d, cl, cfg, lo, hi);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
